// File: rtl/timer_arbiter.sv
// One shared delay down-counter handed out to NREQ requesters, one one-shot wait at a time.
// Define TIMER_ARBITER_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               incr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] delay,
  output logic [NREQ-1:0]    grant,
  output logic [IW-1:0]      owner,
  output logic               busy,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic [NREQ-1:0]         done_q, done_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [DW-1:0]           count_q, count_d;
  logic                    win_vld;
  logic [IW-1:0]           win;
  logic [NREQ-1:0][DW-1:0] delay_a;

  assign delay_a = delay;

`ifdef TIMER_ARBITER_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win     = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] last_q, last_d;
  int            rr_idx;
  logic [IW-1:0] rr_sel;

  // Scan downward in distance so the requester nearest after last_q is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    rr_idx  = 0;
    rr_sel  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_idx = (int'(last_q) + k) % NREQ;
      rr_sel = IW'(rr_idx);
      if (req[rr_sel]) begin
        win_vld = 1'b1;
        win     = rr_sel;
      end
    end
  end

  // Leaving RUN (completion or abort) hands lowest priority to the releasing owner.
  always_comb begin
    last_d = last_q;
    if (state_q == RUN && state_d != RUN) last_d = owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(NREQ - 1);
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    count_d = count_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d      = RUN;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          count_d      = delay_a[win];
        end
      end
      RUN: begin
        // Abort outranks completion when both happen on the same edge.
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (count_q == '0) begin
          state_d         = DONE;
          grant_d         = '0;
          done_d[owner_q] = 1'b1;
        end else if (incr) begin
          count_d = count_q - DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign owner = owner_q;
  assign count = count_q;
  assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized + directed bench for timer_arbiter against a transaction-level reference model.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         incr;
  logic [N-1:0] req;
  logic [N*W-1:0] delay;
  logic [N-1:0] grant, done;
  logic [1:0]   owner;
  logic         busy;
  logic [W-1:0] count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  timer_arbiter #(.NREQ(N), .DW(W)) dut (
    .clk(clk), .rst(rst), .incr(incr), .req(req), .delay(delay),
    .grant(grant), .owner(owner), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = counter free, 1 = allocated, 2 = completion cycle.
  int           m_ph = 0;
  int           m_own = 0;
  int           m_cnt = 0;
  int           m_last = N - 1;
  logic [N-1:0] m_grant = '0;
  logic [N-1:0] m_done = '0;

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef TIMER_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_ph <= 0; m_own <= 0; m_cnt <= 0; m_last <= N - 1; m_grant <= '0; m_done <= '0;
    end else begin
      m_done <= '0;
      if (m_ph == 0) begin
        w = pick(req, m_last);
        if (w >= 0) begin
          m_ph <= 1; m_own <= w; m_cnt <= int'(delay[w*W +: W]); m_grant <= 4'(1 << w);
        end
      end else if (m_ph == 1) begin
        if (!req[m_own]) begin
          m_ph <= 0; m_grant <= '0; m_last <= m_own;
        end else if (m_cnt == 0) begin
          m_ph <= 2; m_grant <= '0; m_done <= 4'(1 << m_own); m_last <= m_own;
        end else if (incr) begin
          m_cnt <= m_cnt - 1;
        end
      end else begin
        m_ph <= 0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_grant", 32'(grant), 32'(m_grant));
      check("m_done", 32'(done), 32'(m_done));
      check("m_busy", 32'(busy), 32'(m_ph == 1));
      if (m_ph == 1) begin
        check("m_owner", 32'(owner), 32'(m_own));
        check("m_count", 32'(count), 32'(m_cnt));
      end
    end
  end

  task automatic wait_grant(input int bound);
    int n = 0;
    while (grant == '0 && n < bound) begin @(negedge clk); n++; end
    if (grant == '0) check("grant_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done == '0 && n < bound) begin @(negedge clk); n++; end
    if (done == '0) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_rr[5];

  initial begin
`ifdef TIMER_ARBITER_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 2, 3, 0};
`endif
    rst = 1'b1; req = '0; incr = 1'b0; delay = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(count), 0);
    check("rst_owner", 32'(owner), 0);
    chk_en = 1'b1;

    // Single request, delay 3, incr held high.
    rst = 1'b0; req = 4'b0001; delay[0 +: W] = 8'd3; incr = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) check("t1_grant", 32'(grant), 32'h1);
      if (c <= 4) check("t1_count", 32'(count), 32'(4 - c));
      if (c < 5)  check("t1_nodone", 32'(done), 0);
      if (c == 5) begin check("t1_done", 32'(done), 32'h1); req = '0; end
    end
    @(negedge clk);
    check("t1_done_once", 32'(done), 0);

    // Zero delay completes with no tick.
    req = 4'b0010; delay[W +: W] = 8'd0; incr = 1'b0;
    @(negedge clk); check("t2_grant", 32'(grant), 32'h2);
    @(negedge clk); check("t2_done", 32'(done), 32'h2); req = '0;
    @(negedge clk);

    // Fairness sweep from reset.
    do_reset();
    req = 4'b1111; incr = 1'b1;
    for (int i = 0; i < N; i++) delay[i*W +: W] = 8'd1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(10);
      check("t3_rr_grant", 32'(grant), 32'(1 << exp_rr[n]));
      wait_done(10);
    end
    req = '0;
    @(negedge clk);

    // Sparse ticks: count must hold between them.
    req = 4'b0100; delay[2*W +: W] = 8'd2; incr = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin check("t4_grant", 32'(grant), 32'h4); check("t4_count0", 32'(count), 2); end
      if (c == 4) check("t4_hold", 32'(count), 1);
      if (c == 6) check("t4_hold2", 32'(count), 1);
      if (c == 7) begin check("t4_zero", 32'(count), 0); check("t4_nodone", 32'(done), 0); end
      if (c == 8) begin check("t4_done", 32'(done), 32'h4); req = '0; end
      incr = (c == 1 || c == 6);
    end
    incr = 1'b0;
    @(negedge clk);

    // Abort of requester 2 at count 6, requester 3 pending.
    do_reset();
    req = 4'b1100; delay[2*W +: W] = 8'd10; delay[3*W +: W] = 8'd4; incr = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) check("t5_grant2", 32'(grant), 32'h4);
      if (c == 5) begin check("t5_count6", 32'(count), 6); req = 4'b1000; end
      if (c == 6) begin
        check("t5_ab_grant", 32'(grant), 0);
        check("t5_ab_busy", 32'(busy), 0);
        check("t5_ab_done", 32'(done), 0);
      end
      if (c == 7) check("t5_grant3", 32'(grant), 32'h8);
    end
    wait_done(20);
    req = '0;
    @(negedge clk);

    // Mid-run reset at count 5.
    req = 4'b0001; delay[0 +: W] = 8'd8;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) begin check("t6_count5", 32'(count), 5); rst = 1'b1; req = 4'b1001; end
      if (c == 5) begin
        check("t6_grant", 32'(grant), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_count", 32'(count), 0);
        check("t6_done", 32'(done), 0);
        rst = 1'b0;
      end
      if (c == 6) check("t6_win0", 32'(grant), 32'h1);
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Random traffic including aborts, re-requests, delay churn and resets.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 299) == 0);
      incr = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
        delay[i*W +: W] = 8'($urandom_range(0, 6));
      end
    end
    rst = 1'b0; req = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
